// File: rtl/o_ddr_tx_pkg.sv
// rtl/o_ddr_tx_pkg.sv - shared types, defaults and helpers for the DDR transmit lane
package o_ddr_tx_pkg;

   // Lane state: preamble training, or normal data/idle transmission
   typedef enum logic {
      TRAIN = 1'b0,
      RUN   = 1'b1
   } tx_state_t;

   localparam logic [1:0] TRAIN_WORD_DEF = 2'b01;
   localparam logic [1:0] IDLE_WORD_DEF  = 2'b00;

   // Address width for a power-of-two depth; never returns 0 so slices stay legal
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/o_ddr_prims.sv
// rtl/o_ddr_prims.sv - behavioural models of the O_DDR and O_BUF_DS pad primitives

// DDR output register: D[0] driven while C is high, D[1] while C is low, one-cycle capture latency
module O_DDR (
   input  logic [1:0] D,
   input  logic       E,
   input  logic       C,
   input  logic       R,
   output logic       Q
);

   logic hi_q;
   logic lo_q;

   // Capture both phases on the rising edge when enabled; active-low async clear
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         hi_q <= 1'b0;
         lo_q <= 1'b0;
      end else if (E) begin
         hi_q <= D[0];
         lo_q <= D[1];
      end
   end

   assign Q = C ? hi_q : lo_q;

endmodule

// Differential output buffer
module O_BUF_DS (
   input  logic I,
   output logic O,
   output logic OB
);

   assign O  = I;
   assign OB = ~I;

endmodule

// File: rtl/o_ddr_tx_fifo.sv
// rtl/o_ddr_tx_fifo.sv - small word FIFO with extra-bit pointers for the DDR transmit lane
module o_ddr_tx_fifo
   import o_ddr_tx_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = ptr_width(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Pointers differ only in the wrap bit when every slot is occupied
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer update; simultaneous push and pop leave occupancy unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; contents are meaningless until pointed at by a push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/o_ddr_ds_tx.sv
// rtl/o_ddr_ds_tx.sv - transmit DDR lane: FIFO, training FSM and differential pad driver
module o_ddr_ds_tx
   import o_ddr_tx_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 4,
   parameter int         TRAIN_CYCLES = 16,
   parameter logic [1:0] TRAIN_WORD   = TRAIN_WORD_DEF,
   parameter logic [1:0] IDLE_WORD    = IDLE_WORD_DEF
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic       train_i,
   output logic       busy_o,
   output logic [1:0] tx_word_o,
   output logic       data_p_o,
   output logic       data_n_o
);

   localparam int            CW       = ptr_width(TRAIN_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TRAIN_CYCLES - 1);
   // A training request word is itself the first preamble word of the run
   localparam logic          ONE_WORD = (TRAIN_CYCLES == 1);

   tx_state_t   state_q;
   tx_state_t   state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [1:0]  tx_word_q;
   logic [1:0]  tx_word_d;
   logic        busy_q;
   logic        busy_d;
   logic        last_word;
   logic        pop;
   logic        push;
   logic        fifo_full;
   logic        fifo_empty;
   logic [1:0]  fifo_head;
   logic        ddr_q;

   assign ready_o   = enable && !fifo_full && !reset;
   assign push      = valid_i && ready_o;
   assign busy_o    = busy_q;
   assign tx_word_o = tx_word_q;

   // The word loaded this cycle closes the training run
   assign last_word = train_i ? ONE_WORD : (state_q == TRAIN) && (cnt_q == CNT_LAST);

   o_ddr_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (reset),
      .push  (push),
      .wdata (data_i),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // State register, advancing only on enabled cycles
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset)       state_q <= TRAIN;
      else if (enable) state_q <= state_d;
   end

   // Next state: training runs until the last preamble word, a request restarts it
   always_comb begin
      state_d = state_q;
      if (train_i || state_q == TRAIN) begin
         state_d = last_word ? RUN : TRAIN;
      end
   end

   // Word selection, FIFO pop and train counter for the coming edge
   always_comb begin
      cnt_d     = cnt_q;
      tx_word_d = tx_word_q;
      busy_d    = busy_q;
      pop       = 1'b0;
      if (enable) begin
         if (train_i || state_q == TRAIN) begin
            tx_word_d = TRAIN_WORD;
            busy_d    = 1'b1;
            if (last_word)    cnt_d = '0;
            else if (train_i) cnt_d = CW'(1);
            else              cnt_d = cnt_q + CW'(1);
         end else begin
            busy_d = 1'b0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               tx_word_d = fifo_head;
            end else begin
               tx_word_d = IDLE_WORD;
            end
         end
      end
   end

   // Output word, busy flag and counter registers
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         tx_word_q <= 2'b00;
         busy_q    <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         tx_word_q <= tx_word_d;
         busy_q    <= busy_d;
      end
   end

   O_DDR u_ddr (
      .D (tx_word_q),
      .E (enable),
      .C (clk_i),
      .R (~reset),
      .Q (ddr_q)
   );

   O_BUF_DS u_obuf (
      .I  (ddr_q),
      .O  (data_p_o),
      .OB (data_n_o)
   );

endmodule

// File: tb/tb_o_ddr_ds_tx.sv
// tb/tb_o_ddr_ds_tx.sv - directed self-checking bench for o_ddr_ds_tx
module tb_o_ddr_ds_tx;

   logic       clk_i = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic       train_i;
   logic       busy_o;
   logic [1:0] tx_word_o;
   logic       data_p_o;
   logic       data_n_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] b2b  [5];
   logic [1:0] fill [4];
   logic [1:0] prev;

   always #5 clk_i = ~clk_i;

   o_ddr_ds_tx dut (
      .clk_i     (clk_i),
      .reset     (reset),
      .enable    (enable),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .train_i   (train_i),
      .busy_o    (busy_o),
      .tx_word_o (tx_word_o),
      .data_p_o  (data_p_o),
      .data_n_o  (data_n_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      b2b[0] = 2'b11; b2b[1] = 2'b10; b2b[2] = 2'b01; b2b[3] = 2'b00; b2b[4] = 2'b11;
      fill[0] = 2'b11; fill[1] = 2'b01; fill[2] = 2'b10; fill[3] = 2'b00;

      reset = 1'b1; enable = 1'b0; valid_i = 1'b0; train_i = 1'b0; data_i = 2'b00;
      #12;
      @(negedge clk_i);
      check_val("rst_tx", tx_word_o, 2'b00);
      check_val("rst_busy", busy_o, 1'b1);
      check_val("rst_ready", ready_o, 1'b0);
      check_val("rst_pad_p", data_p_o, 1'b0);
      check_val("rst_pad_n", data_n_o, 1'b1);
      enable = 1'b1;
      #1;
      check_val("rst_ready_en", ready_o, 1'b0);
      reset = 1'b0;
      #1;
      check_val("ready_first", ready_o, 1'b1);

      // Initial training run; one word pushed during training cycle 3
      for (int i = 0; i < 16; i++) begin
         valid_i = (i == 3);
         data_i  = 2'b10;
         @(posedge clk_i);
         #1;
         if (i == 5) begin
            check_val("pad_hi_p", data_p_o, 1'b1);
            check_val("pad_hi_n", data_n_o, 1'b0);
         end
         @(negedge clk_i);
         valid_i = 1'b0;
         check_val("train_tx", tx_word_o, 2'b01);
         check_val("train_busy", busy_o, 1'b1);
         if (i == 5) check_val("pad_lo_p", data_p_o, 1'b0);
      end
      step();
      check_val("first_run_tx", tx_word_o, 2'b10);
      check_val("first_run_busy", busy_o, 1'b0);
      step();
      check_val("idle_tx", tx_word_o, 2'b00);
      check_val("idle_busy", busy_o, 1'b0);
      check_val("pad_lo_p10", data_p_o, 1'b1);
      check_val("pad_lo_n10", data_n_o, 1'b0);
      step();
      check_val("idle_tx2", tx_word_o, 2'b00);
      check_val("idle_ready", ready_o, 1'b1);

      // Back-to-back pushes in RUN, each word one cycle after acceptance
      prev = 2'b00;
      for (int j = 0; j < 5; j++) begin
         data_i  = b2b[j];
         valid_i = 1'b1;
         #1;
         check_val("b2b_ready", ready_o, 1'b1);
         step();
         check_val("b2b_tx", tx_word_o, prev);
         prev = b2b[j];
      end
      valid_i = 1'b0;
      step();
      check_val("b2b_last", tx_word_o, 2'b11);
      step();
      check_val("b2b_idle", tx_word_o, 2'b00);

      // Training request in RUN with two words queued, enable gap mid-training
      train_i = 1'b1; valid_i = 1'b1; data_i = 2'b10;
      step();
      train_i = 1'b0; data_i = 2'b01;
      check_val("rtrain_tx0", tx_word_o, 2'b01);
      check_val("rtrain_busy0", busy_o, 1'b1);
      step();
      valid_i = 1'b0;
      check_val("rtrain_tx1", tx_word_o, 2'b01);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("rtrain_tx", tx_word_o, 2'b01);
      end
      enable = 1'b0; valid_i = 1'b1; data_i = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_val("dis_ready", ready_o, 1'b0);
         step();
         check_val("dis_tx", tx_word_o, 2'b01);
         check_val("dis_busy", busy_o, 1'b1);
      end
      enable = 1'b1; valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_val("rtrain_tail", tx_word_o, 2'b01);
         check_val("rtrain_busy", busy_o, 1'b1);
      end
      step();
      check_val("rtrain_q0", tx_word_o, 2'b10);
      check_val("rtrain_done", busy_o, 1'b0);
      step();
      check_val("rtrain_q1", tx_word_o, 2'b01);
      step();
      check_val("rtrain_idle", tx_word_o, 2'b00);

      // Asynchronous reset in the middle of a burst
      valid_i = 1'b1; data_i = 2'b11;
      step();
      data_i = 2'b10;
      step();
      check_val("burst_tx", tx_word_o, 2'b11);
      @(posedge clk_i);
      #2;
      check_val("pre_rst_tx", tx_word_o, 2'b10);
      reset = 1'b1;
      #1;
      check_val("mrst_tx", tx_word_o, 2'b00);
      check_val("mrst_busy", busy_o, 1'b1);
      check_val("mrst_ready", ready_o, 1'b0);
      check_val("mrst_pad_p", data_p_o, 1'b0);
      check_val("mrst_pad_n", data_n_o, 1'b1);
      valid_i = 1'b0;
      @(negedge clk_i);
      reset = 1'b0;

      // Fill the FIFO during training, hold off a fifth word until RUN drains
      for (int i = 0; i < 16; i++) begin
         data_i  = (i < 4) ? fill[i] : 2'b10;
         valid_i = 1'b1;
         #1;
         check_val("fill_ready", ready_o, (i < 4) ? 1'b1 : 1'b0);
         step();
         check_val("fill_train_tx", tx_word_o, 2'b01);
      end
      #1;
      check_val("full_ready", ready_o, 1'b0);
      step();
      check_val("drain0", tx_word_o, 2'b11);
      check_val("drain_busy", busy_o, 1'b0);
      check_val("drain_ready", ready_o, 1'b1);
      step();
      valid_i = 1'b0;
      check_val("drain1", tx_word_o, 2'b01);
      step();
      check_val("drain2", tx_word_o, 2'b10);
      step();
      check_val("drain3", tx_word_o, 2'b00);
      step();
      check_val("drain_fifth", tx_word_o, 2'b10);
      step();
      check_val("drain_idle", tx_word_o, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
